// File: rtl/dbg_cmd_dispatch.sv
// dbg_cmd_dispatch: system-clock side of the debug slave.
// Synchronises the TCK-domain update-IR/update-DR strobes, captures
// {IR, DR} on each update-DR, filters by a per-channel enable mask and
// buffers accepted commands in a first-word-fall-through FIFO.
// Optional feature: define DBG_CMD_TIMESTAMP_EN to store a free-running
// TS_W-bit timestamp with every entry (cmd_ts is tied to 0 otherwise).
//
// Handshake: cmd_valid is high whenever the FIFO holds an entry; the head
// (cmd_ch/cmd_data/cmd_ts) is stable until the cycle cmd_valid & cmd_ready
// is sampled high on a clk edge, which pops it. cmd_ready may be held high
// continuously and has no effect while cmd_valid is low.
module dbg_cmd_dispatch #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int TS_W        = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          vs_uir,
    input  logic                          vs_udr,
    input  logic [IR_W-1:0]               ir_in,
    input  logic [DATA_W-1:0]             sr,
    input  logic [(2**IR_W)-1:0]          ch_en,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [IR_W-1:0]               cmd_ch,
    output logic [DATA_W-1:0]             cmd_data,
    output logic [TS_W-1:0]               cmd_ts,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovf,
    input  logic                          ovf_clr,
    output logic [CNT_W-1:0]              drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = $clog2(SYNC_STAGES + 2);
    localparam int EW = IR_W + DATA_W;
    localparam logic [PW-1:0] PRIME_DONE = PW'(SYNC_STAGES + 1);
    localparam logic [LW-1:0] FULL_LVL   = LW'(FIFO_DEPTH);

    // Synchroniser and edge-detect state
    logic [SYNC_STAGES-1:0] r_uir_sync;
    logic [SYNC_STAGES-1:0] r_udr_sync;
    logic                   r_uir_d;
    logic                   r_udr_d;
    logic [PW-1:0]          r_prime;
    logic [IR_W-1:0]        r_ir_q;

    // Capture stage between the edge detector and the FIFO write port
    logic                   r_cap_valid;
    logic [EW-1:0]          r_cap_cmd;

    // FIFO storage and bookkeeping
    logic [EW-1:0]          r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [LW-1:0]          r_count;
    logic [EW-1:0]          r_last;
    logic                   r_ovf;
    logic [CNT_W-1:0]       r_drop_cnt;

    logic                   w_armed;
    logic                   w_uir_rise;
    logic                   w_udr_rise;
    logic [IR_W-1:0]        w_cur_ch;
    logic                   w_ch_ok;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_ovf_evt;
    logic [EW-1:0]          w_head;
    logic [EW-1:0]          w_out;

    // Edges are only honoured once the chains have flushed after reset, so a
    // strobe already high at reset release is not mistaken for a new edge.
    assign w_armed    = (r_prime == PRIME_DONE);
    assign w_uir_rise = w_armed & r_uir_sync[SYNC_STAGES-1] & ~r_uir_d;
    assign w_udr_rise = w_armed & r_udr_sync[SYNC_STAGES-1] & ~r_udr_d;

    // A coincident update-IR supplies the channel for this update-DR.
    assign w_cur_ch   = w_uir_rise ? ir_in : r_ir_q;
    assign w_ch_ok    = ch_en[w_cur_ch];

    assign cmd_valid  = (r_count != '0);
    assign w_full     = (r_count == FULL_LVL);
    assign w_pop      = cmd_valid & cmd_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_push     = r_cap_valid & (~w_full | w_pop);
    assign w_ovf_evt  = r_cap_valid & w_full & ~w_pop;

    assign w_head     = r_mem[r_rd_ptr];
    assign w_out      = cmd_valid ? w_head : r_last;
    assign cmd_ch     = w_out[EW-1:DATA_W];
    assign cmd_data   = w_out[DATA_W-1:0];
    assign fifo_level = r_count;
    assign ovf        = r_ovf;
    assign drop_cnt   = r_drop_cnt;

    // Strobe synchronisers, edge-detect delay flops and post-reset prime counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_uir_sync <= '0;
            r_udr_sync <= '0;
            r_uir_d    <= 1'b0;
            r_udr_d    <= 1'b0;
            r_prime    <= '0;
        end else begin
            r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
            r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
            r_uir_d    <= r_uir_sync[SYNC_STAGES-1];
            r_udr_d    <= r_udr_sync[SYNC_STAGES-1];
            if (!w_armed) begin
                r_prime <= r_prime + PW'(1);
            end
        end
    end

    // Virtual IR latch, command capture, channel filtering and drop counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir_q      <= '0;
            r_cap_valid <= 1'b0;
            r_cap_cmd   <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_uir_rise) begin
                r_ir_q <= ir_in;
            end
            r_cap_valid <= w_udr_rise & w_ch_ok;
            if (w_udr_rise) begin
                r_cap_cmd <= {w_cur_ch, sr};
            end
            if (w_udr_rise && !w_ch_ok && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    // FIFO data array; contents are only observed through valid entries
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_cap_cmd;
        end
    end

    // FIFO pointers, occupancy, held output value and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_last   <= w_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef DBG_CMD_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_ts_mem [FIFO_DEPTH];
    logic [TS_W-1:0] r_ts_last;

    assign cmd_ts = cmd_valid ? r_ts_mem[r_rd_ptr] : r_ts_last;

    // Free-running timestamp and held value of the last popped timestamp
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts      <= '0;
            r_ts_last <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
            if (w_pop) begin
                r_ts_last <= r_ts_mem[r_rd_ptr];
            end
        end
    end

    // Timestamp array written alongside the command in the push cycle
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ts_mem[r_wr_ptr] <= r_ts;
        end
    end
`else
    assign cmd_ts = '0;
`endif

endmodule

// File: tb/tb_dbg_cmd_dispatch.sv
// tb_dbg_cmd_dispatch: directed self-checking bench for dbg_cmd_dispatch
// (default parameters, SYNC_STAGES = 2, FIFO_DEPTH = 4).
module tb_dbg_cmd_dispatch;

    localparam int DATA_W = 38;
    localparam int IR_W   = 2;
    localparam int TS_W   = 16;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              vs_uir;
    logic              vs_udr;
    logic [IR_W-1:0]   ir_in;
    logic [DATA_W-1:0] sr;
    logic [3:0]        ch_en;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [IR_W-1:0]   cmd_ch;
    logic [DATA_W-1:0] cmd_data;
    logic [TS_W-1:0]   cmd_ts;
    logic [2:0]        fifo_level;
    logic              ovf;
    logic              ovf_clr;
    logic [CNT_W-1:0]  drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    dbg_cmd_dispatch dut (
        .clk        (clk),
        .reset      (reset),
        .vs_uir     (vs_uir),
        .vs_udr     (vs_udr),
        .ir_in      (ir_in),
        .sr         (sr),
        .ch_en      (ch_en),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ch     (cmd_ch),
        .cmd_data   (cmd_data),
        .cmd_ts     (cmd_ts),
        .fifo_level (fifo_level),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
        .drop_cnt   (drop_cnt)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_uir(input logic [IR_W-1:0] ir);
        ir_in  = ir;
        vs_uir = 1'b1;
        tick(4);
        vs_uir = 1'b0;
        tick(4);
    endtask

    // One update-DR; the command is written on the 4th edge after vs_udr rises
    task automatic udr_pulse(input logic [DATA_W-1:0] d);
        sr     = d;
        vs_udr = 1'b1;
        tick(3);
        vs_udr = 1'b0;
        tick(3);
    endtask

    initial begin
        int any_valid;
        int lat;
        logic [TS_W-1:0] ts0;
        logic [TS_W-1:0] ts1;

        reset     = 1'b1;
        vs_uir    = 1'b0;
        vs_udr    = 1'b1;
        ir_in     = '0;
        sr        = '0;
        ch_en     = 4'hF;
        cmd_ready = 1'b0;
        ovf_clr   = 1'b0;
        tick(3);

        // Reset values
        check("rst_valid", cmd_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", ovf, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_data", cmd_data, 0);
        check("rst_ts", cmd_ts, 0);

        // Release with vs_udr already high: no spurious command
        reset = 1'b0;
        any_valid = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cmd_valid) any_valid = 1;
        end
        check("prime_no_valid", any_valid, 0);
        check("prime_level", fifo_level, 0);
        vs_udr = 1'b0;
        tick(4);

        // Latency and content of a single command on channel 1
        do_uir(2'b01);
        sr     = 38'h2A_DEAD_BEEF;
        vs_udr = 1'b1;
        lat    = 0;
        while (!cmd_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("udr_latency", lat, 4);
        check("udr_ch", cmd_ch, 1);
        check("udr_data", cmd_data, 38'h2A_DEAD_BEEF);
        vs_udr = 1'b0;
        tick(2);
        check("hold_stable", cmd_data, 38'h2A_DEAD_BEEF);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("pop_valid", cmd_valid, 0);
        check("pop_hold_data", cmd_data, 38'h2A_DEAD_BEEF);

        // Overflow: five commands into a four-entry FIFO with no consumer
        do_uir(2'b00);
        for (int i = 1; i <= 5; i++) udr_pulse(DATA_W'(i));
        check("ovf_level", fifo_level, 4);
        check("ovf_set", ovf, 1);
        cmd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_valid", cmd_valid, 1);
            check("drain_data", cmd_data, i);
            tick();
        end
        cmd_ready = 1'b0;
        check("drain_empty", cmd_valid, 0);
        check("ovf_sticky", ovf, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", ovf, 0);

        // Full FIFO: pop in the same cycle the next command is written
        for (int i = 0; i < 4; i++) udr_pulse(DATA_W'(8'h10 + i));
        check("full_level", fifo_level, 4);
        sr     = 38'h14;
        vs_udr = 1'b1;
        tick(3);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("pushpop_level", fifo_level, 4);
        check("pushpop_ovf", ovf, 0);
        vs_udr = 1'b0;
        tick(3);
        check("pushpop_level2", fifo_level, 4);
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("pushpop_order", cmd_data, 8'h11 + i);
            tick();
        end
        check("pushpop_empty", fifo_level, 0);

        // cmd_ready while empty has no effect
        tick(2);
        cmd_ready = 1'b0;
        check("empty_ready_level", fifo_level, 0);
        check("empty_ready_valid", cmd_valid, 0);

        // Coincident update-IR and update-DR use the new IR value
        ir_in  = 2'b10;
        sr     = 38'h77;
        vs_uir = 1'b1;
        vs_udr = 1'b1;
        tick(6);
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        tick(3);
        check("coinc_ch", cmd_ch, 2);
        check("coinc_data", cmd_data, 38'h77);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;

        // Channel mask: channel 1 disabled, drop counter saturates
        ch_en = 4'b1101;
        do_uir(2'b01);
        udr_pulse(38'h1);
        check("drop_first", drop_cnt, 1);
        for (int i = 0; i < 299; i++) udr_pulse(38'h1);
        check("drop_sat", drop_cnt, 255);
        check("drop_level", fifo_level, 0);
        check("drop_valid", cmd_valid, 0);
        check("drop_no_ovf", ovf, 0);
        ch_en = 4'hF;

        // Two commands 7 cycles apart on channel 3
        do_uir(2'b11);
        sr     = 38'hA1;
        vs_udr = 1'b1;
        tick(3);
        vs_udr = 1'b0;
        tick(4);
        sr     = 38'hA2;
        vs_udr = 1'b1;
        tick(3);
        vs_udr = 1'b0;
        tick(4);
        check("ts_level", fifo_level, 2);
        check("ts_data0", cmd_data, 38'hA1);
        ts0 = cmd_ts;
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("ts_data1", cmd_data, 38'hA2);
        ts1 = cmd_ts;
`ifdef DBG_CMD_TIMESTAMP_EN
        check("ts_delta", TS_W'(ts1 - ts0), 7);
`else
        check("ts_zero0", ts0, 0);
        check("ts_zero1", ts1, 0);
`endif
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;

        // Reset mid-stream discards buffered commands
        udr_pulse(38'h9);
        check("mid_level", fifo_level, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", cmd_valid, 0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_data", cmd_data, 0);
        check("mid_rst_drop", drop_cnt, 0);
        tick(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
